// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding, add/sub mode constant and counter sizing for the restoring divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Mode input of the add/sub stage that selects subtraction (b inverted, carry-in set)
    localparam logic ADDSUB_SUB = 1'b1;

    // Bits needed to hold values 0 .. value-1; callers pass WIDTH+1 so WIDTH itself fits
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub_stage.sv
// rtl/addsub_stage.sv - N-bit ripple-carry adder/subtractor (mode=1 subtracts via inverted b and carry-in)
module addsub_stage #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         mode,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N-1:0] b_eff;
    logic         carry;

    // Walk the carry from bit 0 upward, one full adder per bit
    always_comb begin
        b_eff = b ^ {N{mode}};
        carry = mode;
        sum   = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b_eff[i] ^ carry;
            carry  = (a[i] & b_eff[i]) | (carry & (a[i] ^ b_eff[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - unsigned restoring divider, one quotient bit per clock; optional DIV_ZERO_DETECT_EN
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   trial;
    logic             no_borrow;
    logic [WIDTH:0]   p_next;
    logic [WIDTH-1:0] q_next;

`ifdef DIV_ZERO_DETECT_EN
    logic             zero_op;
    logic             div_zero_r;
    assign div_zero = div_zero_r;
`else
    assign div_zero = 1'b0;
`endif

    // {P,Q} shifted left by one; P's top bit is always 0 between steps so the shift loses nothing
    assign p_shift = (p << 1) | {{WIDTH{1'b0}}, q[WIDTH-1]};

    addsub_stage #(
        .N (WIDTH + 1)
    ) u_trial (
        .a    (p_shift),
        .b    ({1'b0, dvs}),
        .mode (ADDSUB_SUB),
        .sum  (trial),
        .cout (no_borrow)
    );

    // Keep the trial difference when it did not borrow, otherwise restore the shifted P
    always_comb begin
        p_next = no_borrow ? trial : p_shift;
        q_next = {q[WIDTH-2:0], no_borrow};
    end

    // Control FSM and datapath registers; results are captured only on the edge entering DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            p         <= '0;
            q         <= '0;
            dvs       <= '0;
            count     <= '0;
`ifdef DIV_ZERO_DETECT_EN
            zero_op    <= 1'b0;
            div_zero_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        q     <= dividend;
                        dvs   <= divisor;
                        p     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef DIV_ZERO_DETECT_EN
                        zero_op <= (divisor == '0);
                        count   <= (divisor == '0) ? CW'(1) : CW'(WIDTH);
`else
                        count <= CW'(WIDTH);
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
`ifdef DIV_ZERO_DETECT_EN
                    if (zero_op) begin
                        // Zero divisor short-cut: report the natural all-ones / dividend result at once
                        quotient   <= '1;
                        remainder  <= q;
                        div_zero_r <= 1'b1;
                        count      <= '0;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= DONE;
                    end else
`endif
                    begin
                        p     <= p_next;
                        q     <= q_next;
                        count <= count - CW'(1);
                        if (count == CW'(1)) begin
                            quotient  <= q_next;
                            remainder <= p_next[WIDTH-1:0];
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= DONE;
`ifdef DIV_ZERO_DETECT_EN
                            div_zero_r <= 1'b0;
`endif
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - randomized and directed bench for seq_restoring_divider against a / and % model
module tb_seq_restoring_divider;

`ifdef DIV_ZERO_DETECT_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    int vectors;
    int miscompares;

    seq_restoring_divider #(
        .WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one division from the current cycle and follow it to done; optionally spray ignored starts while busy
    task automatic run_div(input logic [3:0] a, input logic [3:0] b, input bit noise,
                           output int lat, output int bc);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
        lat = 0;
        bc  = 0;
        while (!done && lat < 20) begin
            if (busy) begin
                bc++;
                if (noise) begin
                    start    = 1'($urandom_range(0, 1));
                    dividend = 4'($urandom);
                    divisor  = 4'($urandom);
                end
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic check_div(input logic [3:0] a, input logic [3:0] b, input bit noise);
        int lat;
        int bc;
        int exp_q;
        int exp_r;
        int exp_lat;
        string tag;
        exp_q   = (b == 0) ? 15 : int'(a) / int'(b);
        exp_r   = (b == 0) ? int'(a) : int'(a) % int'(b);
        exp_lat = (ZD && b == 0) ? 1 : 4;
        run_div(a, b, noise, lat, bc);
        tag = $sformatf("%0d/%0d", a, b);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy_cycles"}, bc, exp_lat);
        check({tag, " done"}, done, 1);
        check({tag, " quotient"}, quotient, exp_q);
        check({tag, " remainder"}, remainder, exp_r);
        check({tag, " div_zero"}, div_zero, (ZD && b == 0) ? 1 : 0);
    endtask

    initial begin
        int lat;
        int bc;
        bit saw_done;
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        tick();
        tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset div_zero", div_zero, 0);
        rst = 1'b0;
        tick();

        // Directed cases
        check_div(4'd13, 4'd3, 1'b0);
        tick();
        check("done one cycle", done, 0);
        check("13/3 held quotient", quotient, 4);
        check_div(4'd15, 4'd1, 1'b0);
        check_div(4'd5, 4'd7, 1'b0);
        check_div(4'd0, 4'd5, 1'b0);
        check_div(4'd7, 4'd0, 1'b0);
        tick();

        // Start while busy is ignored; start in the done cycle is accepted
        start = 1'b1; dividend = 4'd9; divisor = 4'd2;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1; dividend = 4'd14; divisor = 4'd3;
        tick();
        start = 1'b0;
        check("ignored start busy", busy, 1);
        tick();
        check("9/2 done", done, 1);
        check("9/2 quotient", quotient, 4);
        check("9/2 remainder", remainder, 1);
        start = 1'b1; dividend = 4'd14; divisor = 4'd3;
        tick();
        start = 1'b0;
        check("b2b busy", busy, 1);
        check("b2b held quotient", quotient, 4);
        repeat (3) tick();
        check("b2b not yet done", done, 0);
        tick();
        check("14/3 done", done, 1);
        check("14/3 quotient", quotient, 4);
        check("14/3 remainder", remainder, 2);
        tick();

        // Reset mid-operation aborts without a done pulse
        start = 1'b1; dividend = 4'd11; divisor = 4'd4;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort quotient", quotient, 0);
        check("abort remainder", remainder, 0);
        saw_done = 1'b0;
        repeat (6) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check("abort no done", saw_done, 0);
        check_div(4'd11, 4'd4, 1'b0);
        tick();

        // Reset beats a simultaneous start
        rst = 1'b1; start = 1'b1; dividend = 4'd5; divisor = 4'd1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst+start busy", busy, 0);
        tick();
        check("rst+start stays idle", busy, 0);

        // Exhaustive sweep, back to back
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                check_div(4'(a), 4'(b), 1'b0);
            end
        end

        // Random operations with idle gaps and ignored start noise
        for (int k = 0; k < 200; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            check_div(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
